// File: rtl/pulse_train_monitor.sv
// Pulse-train monitor: synchronizes one async line and measures
// high width and rise-to-rise period in clk cycles.
module pulse_train_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             timeout,
  output logic             sat
);

  typedef enum logic [1:0] {
    IDLE, ARM, HIGH, LOW
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);
  // A TIMEOUT beyond the counter range can never be reached
  localparam bit TO_EN = (TIMEOUT > 0) &&
    (longint'(TIMEOUT) < (longint'(1) << CNT_W));

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   in_d_q;
  logic [CNT_W-1:0]       hcnt_q;
  logic [CNT_W-1:0]       pcnt_q;
  logic [CNT_W-1:0]       width_q;
  logic [CNT_W-1:0]       period_q;
  logic [CNT_W-1:0]       pcnt_o_q;
  logic                   mv_q;
  logic                   to_q;
  logic                   sat_q;

  logic             in_s;
  logic             rise;
  logic             fall;
  logic             h_max;
  logic             p_max;
  logic             to_hit;
  logic [CNT_W-1:0] h_inc;
  logic [CNT_W-1:0] p_inc;

  assign in_s   = sync_q[SYNC_STAGES-1];
  assign rise   = in_s & ~in_d_q;
  assign fall   = ~in_s & in_d_q;
  assign h_max  = &hcnt_q;
  assign p_max  = &pcnt_q;
  assign h_inc  = h_max ? hcnt_q : hcnt_q + ONE;
  assign p_inc  = p_max ? pcnt_q : pcnt_q + ONE;
  assign to_hit = TO_EN && (pcnt_q == TO_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      in_d_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      in_d_q <= in_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      pcnt_q   <= '0;
      width_q  <= '0;
      period_q <= '0;
      pcnt_o_q <= '0;
      mv_q     <= 1'b0;
      to_q     <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      mv_q <= 1'b0;
      if (!en) begin
        state_q  <= IDLE;
        hcnt_q   <= '0;
        pcnt_q   <= '0;
        pcnt_o_q <= '0;
        to_q     <= 1'b0;
        sat_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= ARM;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
          end
          ARM: begin
            if (rise) begin
              hcnt_q  <= ONE;
              pcnt_q  <= ONE;
              state_q <= HIGH;
            end else if (to_hit) begin
              to_q   <= 1'b1;
              hcnt_q <= '0;
              pcnt_q <= '0;
            end else begin
              pcnt_q <= p_inc;
              if (p_max) sat_q <= 1'b1;
            end
          end
          HIGH: begin
            if (to_hit) begin
              to_q    <= 1'b1;
              hcnt_q  <= '0;
              pcnt_q  <= '0;
              state_q <= ARM;
            end else begin
              pcnt_q <= p_inc;
              if (p_max) sat_q <= 1'b1;
              if (fall) begin
                state_q <= LOW;
              end else begin
                hcnt_q <= h_inc;
                if (h_max) sat_q <= 1'b1;
              end
            end
          end
          LOW: begin
            if (rise) begin
              width_q  <= hcnt_q;
              period_q <= pcnt_q;
              mv_q     <= 1'b1;
              pcnt_o_q <= pcnt_o_q + ONE;
              hcnt_q   <= ONE;
              pcnt_q   <= ONE;
              state_q  <= HIGH;
            end else if (to_hit) begin
              to_q    <= 1'b1;
              hcnt_q  <= '0;
              pcnt_q  <= '0;
              state_q <= ARM;
            end else begin
              pcnt_q <= p_inc;
              if (p_max) sat_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign width      = width_q;
  assign period     = period_q;
  assign meas_valid = mv_q;
  assign pulse_cnt  = pcnt_o_q;
  assign timeout    = to_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_pulse_train_monitor.sv
// Directed bench for pulse_train_monitor: measurement, timeout,
// saturation, enable drop and asynchronous reset.
module tb_pulse_train_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pin;
  logic [15:0] width;
  logic [15:0] period;
  logic        mv;
  logic [15:0] pcnt;
  logic        tmo;
  logic        sat;

  logic        en2;
  logic        p2;
  logic [3:0]  width2;
  logic [3:0]  period2;
  logic        mv2;
  logic [3:0]  pcnt2;
  logic        tmo2;
  logic        sat2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mv2_n = 0;
  int wq[$];
  int pq[$];
  int cq[$];
  int tq[$];

  always #5 clk = ~clk;

  pulse_train_monitor #(
    .CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(50)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .pulse_in(pin),
    .width(width), .period(period), .meas_valid(mv),
    .pulse_cnt(pcnt), .timeout(tmo), .sat(sat)
  );

  pulse_train_monitor #(
    .CNT_W(4), .SYNC_STAGES(3), .TIMEOUT(0)
  ) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .pulse_in(p2),
    .width(width2), .period(period2), .meas_valid(mv2),
    .pulse_cnt(pcnt2), .timeout(tmo2), .sat(sat2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mv) begin
      wq.push_back(int'(width));
      pq.push_back(int'(period));
      cq.push_back(int'(pcnt));
      tq.push_back(cyc);
    end
    if (mv2) mv2_n++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic train(input bit sel, input int h,
                       input int p, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < p; c++) begin
        if (sel) p2 = (c < h);
        else pin = (c < h);
        tick(1);
      end
    end
  endtask

  task automatic exp_s(input string s, input int n, input int w,
                       input int p, input int c0, input int per);
    int t;
    int tp;
    tp = 0;
    for (int i = 0; i < n; i++) begin
      if (wq.size() == 0) begin
        chk($sformatf("%s_strobe%0d", s, i), 0, 1);
      end else begin
        t = tq.pop_front();
        chk($sformatf("%s_width%0d", s, i), wq.pop_front(), w);
        chk($sformatf("%s_period%0d", s, i), pq.pop_front(), p);
        chk($sformatf("%s_cnt%0d", s, i), cq.pop_front(), c0 + i);
        if (i > 0) chk($sformatf("%s_gap%0d", s, i), t - tp, per);
        tp = t;
      end
    end
  endtask

  task automatic no_extra(input string s);
    chk({s, "_extra"}, wq.size(), 0);
    wq.delete();
    pq.delete();
    cq.delete();
    tq.delete();
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    pin = 1'b0;
    en2 = 1'b0;
    p2  = 1'b0;
    tick(3);
    chk("rst_width", int'(width), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_mv", int'(mv), 0);
    chk("rst_cnt", int'(pcnt), 0);
    chk("rst_tmo", int'(tmo), 0);
    chk("rst_sat", int'(sat), 0);
    rst = 1'b0;
    en  = 1'b1;
    tick(2);

    train(1'b0, 5, 10, 4);
    exp_s("A", 3, 5, 10, 1, 10);
    no_extra("A");

    train(1'b0, 3, 7, 4);
    exp_s("B0", 1, 5, 10, 4, 0);
    exp_s("B", 3, 3, 7, 5, 7);
    no_extra("B");

    train(1'b0, 5, 50, 3);
    exp_s("C0", 1, 3, 7, 8, 0);
    exp_s("C", 2, 5, 50, 9, 50);
    no_extra("C");

    pin = 1'b1;
    tick(20);
    chk("D_tmo_edge", int'(tmo), 0);
    tick(40);
    chk("D_tmo", int'(tmo), 1);
    chk("D_width", int'(width), 5);
    chk("D_period", int'(period), 50);
    chk("D_cnt", int'(pcnt), 11);
    pin = 1'b0;
    tick(5);
    exp_s("D", 1, 5, 50, 11, 0);
    no_extra("D");

    train(1'b0, 5, 10, 2);
    pin = 1'b1;
    tick(4);
    en = 1'b0;
    tick(3);
    chk("E_cnt", int'(pcnt), 0);
    chk("E_tmo", int'(tmo), 0);
    chk("E_sat", int'(sat), 0);
    chk("E_mv", int'(mv), 0);
    chk("E_width", int'(width), 5);
    chk("E_period", int'(period), 10);
    en  = 1'b1;
    pin = 1'b0;
    tick(3);
    exp_s("E0", 2, 5, 10, 12, 10);
    no_extra("E0");
    train(1'b0, 5, 10, 3);
    exp_s("E", 2, 5, 10, 1, 10);
    no_extra("E");

    train(1'b0, 5, 10, 2);
    pin = 1'b1;
    tick(5);
    pin = 1'b0;
    tick(5);
    exp_s("F0", 3, 5, 10, 3, 10);
    no_extra("F0");
    #3;
    rst = 1'b1;
    #1;
    chk("F_rst_width", int'(width), 0);
    chk("F_rst_period", int'(period), 0);
    chk("F_rst_cnt", int'(pcnt), 0);
    chk("F_rst_tmo", int'(tmo), 0);
    chk("F_rst_mv", int'(mv), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    train(1'b0, 4, 9, 3);
    exp_s("F", 2, 4, 9, 1, 9);
    no_extra("F");

    en2 = 1'b1;
    tick(2);
    chk("S_sat0", int'(sat2), 0);
    train(1'b1, 5, 20, 3);
    chk("S_sat", int'(sat2), 1);
    chk("S_period", int'(period2), 15);
    chk("S_width", int'(width2), 5);
    chk("S_cnt", int'(pcnt2), 2);
    chk("S_strobes", mv2_n, 2);
    chk("S_tmo", int'(tmo2), 0);
    en2 = 1'b0;
    tick(2);
    chk("S_sat_clr", int'(sat2), 0);
    chk("S_cnt_clr", int'(pcnt2), 0);
    chk("S_period_hold", int'(period2), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
